// File: rtl/rv32_register_file_mp_pkg.sv
// Shared types, defaults and the write-port arbitration helper for the RV32
// multi-port register file.
package rv32_rf_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  localparam int AW_DEF    = $clog2(NREGS_DEF);
  localparam int WR_MAX    = 2;

  typedef logic [AW_DEF-1:0]   reg_idx_t;
  typedef logic [XLEN_DEF-1:0] xword_t;

  // Returns {hit, data} for addr; later ports override earlier ones so the
  // highest-index matching port wins. x0 never hits.
  function automatic logic [XLEN_DEF:0] wr_winner(
    input reg_idx_t                   addr,
    input logic [WR_MAX-1:0]          en,
    input logic [WR_MAX*AW_DEF-1:0]   waddr,
    input logic [WR_MAX*XLEN_DEF-1:0] wdata
  );
    logic [XLEN_DEF:0] res;
    res = '0;
    for (int i = 0; i < WR_MAX; i++) begin
      if (en[i] && (addr != '0) && (waddr[i*AW_DEF +: AW_DEF] == addr))
        res = {1'b1, wdata[i*XLEN_DEF +: XLEN_DEF]};
    end
    return res;
  endfunction

endpackage

// File: rtl/rv32_register_file_mp_scoreboard.sv
// Busy scoreboard: issue sets a destination busy, writeback clears it; a
// same-cycle set beats the clear and x0 is never busy.
module rv32_rf_scoreboard
  import rv32_rf_pkg::*;
#(
  parameter int NREGS  = NREGS_DEF,
  parameter int NUM_WR = 1,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_WR-1:0]    wr_en,
  input  logic [NUM_WR*AW-1:0] wr_addr,
  input  logic                 issue_en,
  input  logic [AW-1:0]        issue_rd,
  output logic [NREGS-1:0]     busy
);

  logic [NREGS-1:0] busy_reg;
  logic [NREGS-1:0] busy_next;

  always_comb begin
    busy_next = busy_reg;
    for (int i = 0; i < NUM_WR; i++) begin
      if (wr_en[i] && (wr_addr[i*AW +: AW] != '0))
        busy_next[wr_addr[i*AW +: AW]] = 1'b0;
    end
    // Applied after the clears: a new producer supersedes the retiring one.
    if (issue_en && (issue_rd != '0))
      busy_next[issue_rd] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      busy_reg <= '0;
    else
      busy_reg <= busy_next;
  end

  assign busy = busy_reg;

endmodule

// File: rtl/rv32_register_file_mp.sv
// Multi-port RV32 integer register file with registered, write-first read
// ports, write-conflict flag and an embedded busy scoreboard.
module rv32_register_file_mp
  import rv32_rf_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int NREGS  = NREGS_DEF,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 1,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   rd_hold,
  input  logic [NUM_RD*AW-1:0]   rd_addr,
  output logic [NUM_RD*XLEN-1:0] rd_data,
  input  logic [NUM_WR-1:0]      wr_en,
  input  logic [NUM_WR*AW-1:0]   wr_addr,
  input  logic [NUM_WR*XLEN-1:0] wr_data,
  input  logic                   issue_en,
  input  logic [AW-1:0]          issue_rd,
  output logic [NREGS-1:0]       busy,
  output logic                   wr_conflict
);

  // Flop array rather than RAM: every entry must clear on reset.
  logic [XLEN-1:0] regs_reg [NREGS];

  logic [WR_MAX-1:0]          en_pad;
  logic [WR_MAX*AW_DEF-1:0]   wa_pad;
  logic [WR_MAX*XLEN_DEF-1:0] wd_pad;
  logic                       conflict_next;
  logic                       conflict_reg;

  // Widen the write ports to the helper's fixed shape; unused ports stay idle.
  always_comb begin
    en_pad = '0;
    wa_pad = '0;
    wd_pad = '0;
    for (int i = 0; i < NUM_WR; i++) begin
      en_pad[i]                         = wr_en[i];
      wa_pad[i*AW_DEF +: AW_DEF]        = reg_idx_t'(wr_addr[i*AW +: AW]);
      wd_pad[i*XLEN_DEF +: XLEN_DEF]    = xword_t'(wr_data[i*XLEN +: XLEN]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREGS; r++)
        regs_reg[r] <= '0;
    end else begin
      for (int i = 0; i < NUM_WR; i++) begin
        if (wr_en[i] && (wr_addr[i*AW +: AW] != '0))
          regs_reg[wr_addr[i*AW +: AW]] <= wr_data[i*XLEN +: XLEN];
      end
    end
  end

  always_comb begin
    conflict_next = 1'b0;
    for (int i = 0; i < NUM_WR; i++) begin
      for (int j = i + 1; j < NUM_WR; j++) begin
        if (wr_en[i] && wr_en[j] && (wr_addr[i*AW +: AW] != '0) &&
            (wr_addr[i*AW +: AW] == wr_addr[j*AW +: AW]))
          conflict_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      conflict_reg <= 1'b0;
    else
      conflict_reg <= conflict_next;
  end

  assign wr_conflict = conflict_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [AW-1:0]     ra;
      logic [XLEN_DEF:0] win;
      logic [XLEN-1:0]   value;
      logic [XLEN-1:0]   data_reg;

      assign ra  = rd_addr[gi*AW +: AW];
      assign win = wr_winner(reg_idx_t'(ra), en_pad, wa_pad, wd_pad);

      always_comb begin
        value = '0;
        if (ra != '0)
          value = win[XLEN_DEF] ? win[XLEN-1:0] : regs_reg[ra];
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
          data_reg <= '0;
        else if (!rd_hold)
          data_reg <= value;
      end

      assign rd_data[gi*XLEN +: XLEN] = data_reg;
    end
  endgenerate

  rv32_rf_scoreboard #(
    .NREGS  (NREGS),
    .NUM_WR (NUM_WR)
  ) u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .issue_en (issue_en),
    .issue_rd (issue_rd),
    .busy     (busy)
  );

endmodule

// File: tb/tb_rv32_register_file_mp.sv
// Bench for rv32_register_file_mp (dual write port build): directed steps then
// random traffic against an array/set reference model.
module tb_rv32_register_file_mp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rd_hold;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  wr_en;
  logic [9:0]  wr_addr;
  logic [63:0] wr_data;
  logic        issue_en;
  logic [4:0]  issue_rd;
  logic [31:0] busy;
  logic        wr_conflict;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [31:0] m_regs [32];
  logic [31:0] m_rd   [2];
  logic [31:0] m_busy;
  logic        m_conf;

  rv32_register_file_mp #(
    .XLEN   (32),
    .NREGS  (32),
    .NUM_RD (2),
    .NUM_WR (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rd_hold     (rd_hold),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .issue_en    (issue_en),
    .issue_rd    (issue_rd),
    .busy        (busy),
    .wr_conflict (wr_conflict)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    m_rd[0] = '0;
    m_rd[1] = '0;
    m_busy  = '0;
    m_conf  = 1'b0;
  endtask

  task automatic idle();
    rd_hold  = 1'b0;
    wr_en    = '0;
    wr_addr  = '0;
    wr_data  = '0;
    issue_en = 1'b0;
    issue_rd = '0;
  endtask

  // One clock: predict from the current inputs, step, then compare everything.
  task automatic cycle();
    logic [31:0] nregs [32];
    logic [31:0] nbusy;
    logic        nconf;
    logic        hold;
    logic [4:0]  ra [2];
    logic [4:0]  a;
    nregs = m_regs;
    nbusy = m_busy;
    for (int p = 0; p < 2; p++) begin
      a = wr_addr[p*5 +: 5];
      if (wr_en[p] && a != 5'd0) begin
        nregs[a] = wr_data[p*32 +: 32];
        nbusy[a] = 1'b0;
      end
    end
    if (issue_en && issue_rd != 5'd0) nbusy[issue_rd] = 1'b1;
    nconf = (wr_en == 2'b11) && (wr_addr[4:0] == wr_addr[9:5]) && (wr_addr[4:0] != 5'd0);
    hold  = rd_hold;
    ra[0] = rd_addr[4:0];
    ra[1] = rd_addr[9:5];
    @(posedge clk);
    #1;
    if (!hold) begin
      m_rd[0] = (ra[0] == 5'd0) ? 32'd0 : nregs[ra[0]];
      m_rd[1] = (ra[1] == 5'd0) ? 32'd0 : nregs[ra[1]];
    end
    m_regs = nregs;
    m_busy = nbusy;
    m_conf = nconf;
    cyc++;
    $display("cyc=%0d we=%b wa=%0d/%0d ra=%0d/%0d hold=%b iss=%b:%0d rd=%h/%h busy=%h conf=%b",
             cyc, wr_en, wr_addr[4:0], wr_addr[9:5], ra[0], ra[1], hold, issue_en, issue_rd,
             rd_data[31:0], rd_data[63:32], busy, wr_conflict);
    chk("rd0", rd_data[31:0], m_rd[0]);
    chk("rd1", rd_data[63:32], m_rd[1]);
    chk("busy", busy, m_busy);
    chk("conflict", {31'd0, wr_conflict}, {31'd0, m_conf});
  endtask

  initial begin
    rst_n   = 1'b0;
    rd_addr = '0;
    idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rd0", rd_data[31:0], 32'd0);
    chk("reset_rd1", rd_data[63:32], 32'd0);
    chk("reset_busy", busy, 32'd0);
    chk("reset_conf", {31'd0, wr_conflict}, 32'd0);
    rst_n = 1'b1;

    for (int a = 1; a < 32; a++) begin
      rd_addr = {5'(a), 5'(a)};
      cycle();
    end

    // x5 write then read back
    wr_en = 2'b01; wr_addr = {5'd0, 5'd5}; wr_data = {32'd0, 32'hDEADBEEF}; rd_addr = '0;
    cycle();
    idle(); rd_addr = {5'd0, 5'd5};
    cycle();
    chk("x5_read", rd_data[31:0], 32'hDEADBEEF);

    // x0 write dropped
    wr_en = 2'b01; wr_addr = {5'd0, 5'd0}; wr_data = {32'd0, 32'h1234}; rd_addr = '0;
    cycle();
    idle(); rd_addr = {5'd0, 5'd0};
    cycle();
    chk("x0_read", rd_data[31:0], 32'd0);

    // write-first bypass on port 1
    wr_en = 2'b01; wr_addr = {5'd0, 5'd7}; wr_data = {32'd0, 32'hA5A5A5A5}; rd_addr = {5'd7, 5'd0};
    cycle();
    chk("x7_bypass", rd_data[63:32], 32'hA5A5A5A5);

    // both ports write x9: port 1 wins, conflict pulses once
    idle(); wr_en = 2'b11; wr_addr = {5'd9, 5'd9}; wr_data = {32'h22, 32'h11}; rd_addr = '0;
    cycle();
    chk("x9_conflict", {31'd0, wr_conflict}, 32'd1);
    idle(); rd_addr = {5'd0, 5'd9};
    cycle();
    chk("x9_winner", rd_data[31:0], 32'h22);
    chk("x9_conflict_clr", {31'd0, wr_conflict}, 32'd0);

    // scoreboard set / set-wins / clear
    idle(); issue_en = 1'b1; issue_rd = 5'd3;
    cycle();
    chk("busy3_set", {31'd0, busy[3]}, 32'd1);
    wr_en = 2'b01; wr_addr = {5'd0, 5'd3}; wr_data = {32'd0, 32'h33};
    cycle();
    chk("busy3_setwins", {31'd0, busy[3]}, 32'd1);
    idle(); wr_en = 2'b01; wr_addr = {5'd0, 5'd3}; wr_data = {32'd0, 32'h33};
    cycle();
    chk("busy3_clear", {31'd0, busy[3]}, 32'd0);

    // hold keeps stale data across a write to the held register
    idle(); wr_en = 2'b01; wr_addr = {5'd0, 5'd4}; wr_data = {32'd0, 32'd1};
    cycle();
    idle(); rd_addr = {5'd0, 5'd4};
    cycle();
    rd_hold = 1'b1; wr_en = 2'b01; wr_addr = {5'd0, 5'd4}; wr_data = {32'd0, 32'd2};
    repeat (3) cycle();
    chk("hold_stale", rd_data[31:0], 32'd1);
    idle(); rd_addr = {5'd0, 5'd4};
    cycle();
    chk("hold_release", rd_data[31:0], 32'd2);

    // reset in the middle of a hold clears outputs immediately
    rd_hold = 1'b1; issue_en = 1'b1; issue_rd = 5'd6;
    cycle();
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_rd0", rd_data[31:0], 32'd0);
    chk("midrst_rd1", rd_data[63:32], 32'd0);
    chk("midrst_busy", busy, 32'd0);
    model_reset();
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    cycle();

    for (int n = 0; n < 250; n++) begin
      wr_en    = 2'($urandom_range(0, 3));
      wr_addr  = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      if ($urandom_range(0, 3) == 0) wr_addr = 10'($urandom);
      wr_data  = {32'($urandom), 32'($urandom)};
      rd_addr  = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      if ($urandom_range(0, 3) == 0) rd_addr = 10'($urandom);
      rd_hold  = ($urandom_range(0, 7) == 0);
      issue_en = 1'($urandom_range(0, 1));
      issue_rd = 5'($urandom_range(0, 7));
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
